// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the SDRAM request arbiter and the controller wrapper:
// FSM state encoding and default bus widths.
package sdram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

    localparam int DEFAULT_ADDR_WIDTH = 24;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BWE_WIDTH          = 4;

endpackage

// File: rtl/sdram_arbiter_rr_priority.sv
// Combinational round-robin picker: grants the first requester after the
// previous winner, scanning upward with wrap-around.
module rr_priority #(
    parameter int N_PORTS = 2
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [N_PORTS-1:0] i_last_grant,
    output logic [N_PORTS-1:0] o_grant
);

    int   w_last_idx;
    logic w_found;

    always_comb begin
        o_grant    = '0;
        w_last_idx = 0;
        w_found    = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (i_last_grant[i]) w_last_idx = i;
        end
        // Offset 1 first, so the previous winner is considered last.
        for (int k = 1; k <= N_PORTS; k++) begin
            for (int j = 0; j < N_PORTS; j++) begin
                if (!w_found && i_req[j] && (j == (w_last_idx + k) % N_PORTS)) begin
                    o_grant[j] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Multi-port front end for the SDRAM controller: round-robin grants one
// requester at a time and returns read data on a shared q bus.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int N_PORTS    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_PORTS-1:0]            p_req,
    input  logic [N_PORTS-1:0]            p_we,
    input  logic [N_PORTS*ADDR_WIDTH-1:0] p_addr,
    input  logic [N_PORTS*DATA_WIDTH-1:0] p_data,
    input  logic [N_PORTS*BWE_WIDTH-1:0]  p_bwe,
    output logic [N_PORTS-1:0]            p_ack,
    output logic [N_PORTS-1:0]            p_valid,
    output logic [DATA_WIDTH-1:0]         q,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_data,
    output logic [BWE_WIDTH-1:0]          mem_bwe,
    input  logic                          mem_ack,
    input  logic                          mem_valid,
    input  logic [DATA_WIDTH-1:0]         mem_q,
    output logic [1:0]                    o_dbg_state
);

    // Last grant resets to the top port so port 0 wins the first arbitration.
    localparam logic [N_PORTS-1:0] LAST_GRANT_RESET = {1'b1, {(N_PORTS-1){1'b0}}};

    arb_state_t              r_state;
    arb_state_t              w_next_state;
    logic [N_PORTS-1:0]      r_grant;
    logic [N_PORTS-1:0]      r_last_grant;
    logic [N_PORTS-1:0]      r_p_valid;
    logic [DATA_WIDTH-1:0]   r_q;
    logic [N_PORTS-1:0]      w_rr_grant;
    logic [N_PORTS-1:0]      w_p_ack;
    logic                    w_mem_req;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [BWE_WIDTH-1:0]    w_bwe;

    rr_priority #(
        .N_PORTS (N_PORTS)
    ) u_rr_priority (
        .i_req        (p_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_rr_grant)
    );

    // Request fields follow the granted port in every state.
    always_comb begin
        w_we   = 1'b0;
        w_addr = '0;
        w_data = '0;
        w_bwe  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (r_grant[i]) begin
                w_we   = p_we[i];
                w_addr = p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_data = p_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_bwe  = p_bwe[i*BWE_WIDTH +: BWE_WIDTH];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_p_ack      = '0;
        w_mem_req    = 1'b0;
        case (r_state)
            ARB: begin
                if (|p_req) w_next_state = ISSUE;
            end
            ISSUE: begin
                w_mem_req = 1'b1;
                if (mem_ack) begin
                    w_p_ack      = r_grant;
                    w_next_state = w_we ? ARB : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (mem_valid) w_next_state = ARB;
            end
            default: w_next_state = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ARB;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant      <= '0;
            r_last_grant <= LAST_GRANT_RESET;
            r_q          <= '0;
            r_p_valid    <= '0;
        end else begin
            r_p_valid <= '0;
            if (r_state == ARB && |p_req) r_grant <= w_rr_grant;
            if (r_state == ISSUE && mem_ack) r_last_grant <= r_grant;
            if (r_state == WAIT_RD && mem_valid) begin
                r_q       <= mem_q;
                r_p_valid <= r_grant;
            end
        end
    end

    assign p_ack       = w_p_ack;
    assign p_valid     = r_p_valid;
    assign q           = r_q;
    assign mem_req     = w_mem_req;
    assign mem_we      = w_we;
    assign mem_addr    = w_addr;
    assign mem_data    = w_data;
    assign mem_bwe     = w_bwe;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed and randomized checks of sdram_arbiter against a transaction-level
// model of requesters and an SDRAM controller.
module tb_sdram_arbiter;

    localparam int N  = 2;
    localparam int AW = 24;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    p_req;
    logic [N-1:0]    p_we;
    logic [N*AW-1:0] p_addr;
    logic [N*DW-1:0] p_data;
    logic [N*4-1:0]  p_bwe;
    logic [N-1:0]    p_ack;
    logic [N-1:0]    p_valid;
    logic [DW-1:0]   q;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic [3:0]      mem_bwe;
    logic            mem_ack;
    logic            mem_valid;
    logic [DW-1:0]   mem_q;
    logic [1:0]      o_dbg_state;

    int checks = 0;
    int errors = 0;

    sdram_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .N_PORTS    (N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .p_req       (p_req),
        .p_we        (p_we),
        .p_addr      (p_addr),
        .p_data      (p_data),
        .p_bwe       (p_bwe),
        .p_ack       (p_ack),
        .p_valid     (p_valid),
        .q           (q),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_bwe     (mem_bwe),
        .mem_ack     (mem_ack),
        .mem_valid   (mem_valid),
        .mem_q       (mem_q),
        .o_dbg_state (o_dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    // Round robin: first requester after the last winner, wrapping upward.
    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        int idx;
        for (int off = 1; off <= N; off++) begin
            idx = (last + off) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_port(input int i, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [3:0] b);
        p_we[i]           = we;
        p_addr[i*AW +: AW] = a;
        p_data[i*DW +: DW] = d;
        p_bwe[i*4 +: 4]    = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        p_req     = '0;
        p_we      = '0;
        p_addr    = '0;
        p_data    = '0;
        p_bwe     = '0;
        mem_ack   = 1'b0;
        mem_valid = 1'b0;
        mem_q     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_mem_req();
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL wait_mem_req: mem_req=%b after %0d cycles, required 1", mem_req, n);
        end
    endtask

    task automatic read_to_wait(input int port, input logic [AW-1:0] a);
        set_port(port, 1'b0, a, '0, 4'hF);
        p_req = onehot(port);
        @(negedge clk);
        wait_mem_req();
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        p_req   = '0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (q !== '0 || p_ack !== '0 || p_valid !== '0 || mem_req !== 1'b0 || o_dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: q=%h p_ack=%b p_valid=%b mem_req=%b state=%0d, required 0/0/0/0/0",
                     q, p_ack, p_valid, mem_req, o_dbg_state);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || o_dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL idle_after_reset: mem_req=%b state=%0d, required 0/0", mem_req, o_dbg_state);
        end
    endtask

    task automatic test_alternation();
        logic [N-1:0] exp_ack;
        do_reset();
        set_port(0, 1'b1, 24'h000A00, 32'h1111_0000, 4'hF);
        set_port(1, 1'b1, 24'h000B11, 32'h2222_1111, 4'hF);
        p_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_mem_req();
            checks++;
            if (mem_addr !== p_addr[(k % 2)*AW +: AW]) begin
                errors++;
                $display("FAIL alt_addr[%0d]: mem_addr=%h, required %h", k, mem_addr, p_addr[(k % 2)*AW +: AW]);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            mem_ack = 1'b1;
            #1;
            exp_ack = onehot(k % 2);
            checks++;
            if (p_ack !== exp_ack) begin
                errors++;
                $display("FAIL alt_grant[%0d]: p_ack=%b, required %b", k, p_ack, exp_ack);
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        p_req = '0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        do_reset();
        set_port(0, 1'b0, 24'h000123, '0, 4'hF);
        p_req = 2'b01;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 24'h000123 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL read_issue: mem_req=%b addr=%h we=%b, required 1/000123/0", mem_req, mem_addr, mem_we);
        end
        repeat (2) @(negedge clk);
        mem_ack = 1'b1;
        #1;
        checks++;
        if (p_ack !== 2'b01) begin
            errors++;
            $display("FAIL read_ack: p_ack=%b, required 01", p_ack);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        p_req   = '0;
        checks++;
        if (p_ack !== '0 || mem_req !== 1'b0 || o_dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL read_wait: p_ack=%b mem_req=%b state=%0d, required 00/0/2", p_ack, mem_req, o_dbg_state);
        end
        mem_valid = 1'b1;
        mem_q     = 32'hDEADBEEF;
        #1;
        checks++;
        if (p_valid !== '0) begin
            errors++;
            $display("FAIL read_valid_early: p_valid=%b, required 00", p_valid);
        end
        @(negedge clk);
        mem_valid = 1'b0;
        checks++;
        if (p_valid !== 2'b01 || q !== 32'hDEADBEEF || o_dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL read_data: p_valid=%b q=%h state=%0d, required 01/deadbeef/0", p_valid, q, o_dbg_state);
        end
        @(negedge clk);
        checks++;
        if (p_valid !== '0 || q !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_hold: p_valid=%b q=%h, required 00/deadbeef", p_valid, q);
        end
    endtask

    task automatic test_spurious();
        mem_valid = 1'b1;
        mem_q     = 32'h1234_5678;
        mem_ack   = 1'b1;
        #1;
        checks++;
        if (p_ack !== '0) begin
            errors++;
            $display("FAIL spurious_ack: p_ack=%b, required 00", p_ack);
        end
        @(negedge clk);
        mem_valid = 1'b0;
        mem_ack   = 1'b0;
        checks++;
        if (q !== 32'hDEADBEEF || p_valid !== '0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL spurious_valid: q=%h p_valid=%b mem_req=%b, required deadbeef/00/0", q, p_valid, mem_req);
        end
    endtask

    task automatic test_write_refresh();
        logic [AW-1:0] a;
        a = AW'($urandom);
        do_reset();
        set_port(1, 1'b1, a, 32'hCAFEF00D, 4'b0011);
        p_req = 2'b10;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a ||
                mem_data !== 32'hCAFEF00D || mem_bwe !== 4'b0011) begin
                errors++;
                $display("FAIL write_hold[%0d]: req=%b we=%b addr=%h data=%h bwe=%b, required 1/1/%h/cafef00d/0011",
                         c, mem_req, mem_we, mem_addr, mem_data, mem_bwe, a);
            end
        end
        mem_ack = 1'b1;
        #1;
        checks++;
        if (p_ack !== 2'b10) begin
            errors++;
            $display("FAIL write_ack: p_ack=%b, required 10", p_ack);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        p_req   = '0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (o_dbg_state !== 2'd0 || mem_req !== 1'b0 || p_valid !== '0) begin
                errors++;
                $display("FAIL write_done[%0d]: state=%0d mem_req=%b p_valid=%b, required 0/0/00",
                         c, o_dbg_state, mem_req, p_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        read_to_wait(0, 24'h000040);
        mem_valid = 1'b1;
        mem_q     = 32'hA5A5_5A5A;
        @(negedge clk);
        mem_valid = 1'b0;
        read_to_wait(1, 24'h000080);
        checks++;
        if (o_dbg_state !== 2'd2 || q !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL mid_setup: state=%0d q=%h, required 2/a5a55a5a", o_dbg_state, q);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (q !== '0 || p_valid !== '0 || p_ack !== '0 || mem_req !== 1'b0 ||
            o_dbg_state !== 2'd0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL mid_reset: q=%h p_valid=%b p_ack=%b mem_req=%b state=%0d addr=%h, required all 0",
                     q, p_valid, p_ack, mem_req, o_dbg_state, mem_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_q     = 32'hFFFF_0000;
        @(negedge clk);
        mem_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (p_valid !== '0 || q !== '0) begin
                errors++;
                $display("FAIL mid_after[%0d]: p_valid=%b q=%h, required 00/0", c, p_valid, q);
            end
            @(negedge clk);
        end
    endtask

    // Requesters issue random reads/writes with random gaps; the controller
    // acks and returns data after random delays and injects stray pulses.
    task automatic test_random();
        int            phase;
        int            win;
        int            last_win;
        int            w;
        int            ack_cnt;
        int            vcnt;
        int            gap [N];
        logic [N-1:0]  pend;
        logic [N-1:0]  exp_pv;
        logic [N-1:0]  exp_ack;
        logic [DW-1:0] exp_qv;
        logic          m_we   [N];
        logic [AW-1:0] m_addr [N];
        logic [DW-1:0] m_data [N];
        logic [3:0]    m_bwe  [N];
        do_reset();
        phase    = 0;
        win      = 0;
        last_win = N - 1;
        ack_cnt  = 0;
        vcnt     = 0;
        pend     = '0;
        exp_pv   = '0;
        exp_qv   = '0;
        for (int i = 0; i < N; i++) gap[i] = $urandom_range(0, 3);
        repeat (1500) begin
            @(negedge clk);
            checks++;
            if (mem_req !== (phase == 1)) begin
                errors++;
                $display("FAIL rnd_mem_req: mem_req=%b, required %b", mem_req, phase == 1);
            end
            if (phase == 1) begin
                checks++;
                if (mem_we !== m_we[win] || mem_addr !== m_addr[win] ||
                    mem_data !== m_data[win] || mem_bwe !== m_bwe[win]) begin
                    errors++;
                    $display("FAIL rnd_fields: port %0d we=%b addr=%h data=%h bwe=%b, required %b/%h/%h/%b",
                             win, mem_we, mem_addr, mem_data, mem_bwe,
                             m_we[win], m_addr[win], m_data[win], m_bwe[win]);
                end
            end
            checks++;
            if (p_valid !== exp_pv || q !== exp_qv) begin
                errors++;
                $display("FAIL rnd_read: p_valid=%b q=%h, required %b/%h", p_valid, q, exp_pv, exp_qv);
            end
            exp_pv = '0;
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if (gap[i] == 0) begin
                        pend[i]   = 1'b1;
                        m_we[i]   = 1'($urandom_range(0, 1));
                        m_addr[i] = AW'($urandom);
                        m_data[i] = $urandom;
                        m_bwe[i]  = 4'($urandom_range(0, 15));
                        set_port(i, m_we[i], m_addr[i], m_data[i], m_bwe[i]);
                        gap[i]    = $urandom_range(0, 5);
                    end else begin
                        gap[i]--;
                    end
                end
            end
            p_req     = pend;
            mem_ack   = 1'b0;
            mem_valid = 1'b0;
            mem_q     = $urandom;
            if (phase == 1) begin
                if (ack_cnt == 0) mem_ack = 1'b1;
                else ack_cnt--;
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ack = 1'b1;
            end
            if (phase == 2) begin
                if (vcnt == 0) mem_valid = 1'b1;
                else vcnt--;
            end else if ($urandom_range(0, 7) == 0) begin
                mem_valid = 1'b1;
            end
            #1;
            exp_ack = (phase == 1 && mem_ack) ? onehot(win) : '0;
            checks++;
            if (p_ack !== exp_ack) begin
                errors++;
                $display("FAIL rnd_ack: p_ack=%b, required %b", p_ack, exp_ack);
            end
            if (phase == 0) begin
                w = rr_pick(p_req, last_win);
                if (w >= 0) begin
                    win     = w;
                    phase   = 1;
                    ack_cnt = $urandom_range(0, 4);
                end
            end else if (phase == 1) begin
                if (mem_ack) begin
                    last_win  = win;
                    pend[win] = 1'b0;
                    phase     = m_we[win] ? 0 : 2;
                    vcnt      = $urandom_range(0, 3);
                end
            end else begin
                if (mem_valid) begin
                    exp_pv = onehot(win);
                    exp_qv = mem_q;
                    phase  = 0;
                end
            end
        end
        p_req = '0;
    endtask

    initial begin
        reset     = 1'b0;
        p_req     = '0;
        p_we      = '0;
        p_addr    = '0;
        p_data    = '0;
        p_bwe     = '0;
        mem_ack   = 1'b0;
        mem_valid = 1'b0;
        mem_q     = '0;
        test_reset();
        test_alternation();
        test_single_read();
        test_spurious();
        test_write_refresh();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 24: word address width, the same as the SDRAM controller.
REQ-002 Parameter DATA_WIDTH, default 32: data width.
REQ-003 Parameter N_PORTS, default 2, legal range 2..4: number of requesters; port 0 is instruction fetch, port 1 is data.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 p_req  in  N_PORTS  per-port request, held high until that port's p_ack.
REQ-008 p_we  in  N_PORTS  per-port write enable.
REQ-009 p_addr  in  N_PORTS*ADDR_WIDTH  flattened addresses; port i occupies slice i.
REQ-010 p_data  in  N_PORTS*DATA_WIDTH  flattened write data.
REQ-011 p_bwe  in  N_PORTS*4  flattened byte write enables.
REQ-012 p_ack  out  N_PORTS  one-cycle pulse: the port's request was accepted by the controller.
REQ-013 p_valid  out  N_PORTS  one-cycle pulse: read data for that port is on q.
REQ-014 q  out  DATA_WIDTH  read data, shared by all ports.
REQ-015 mem_req, mem_we, mem_addr, mem_data, mem_bwe  out  1/1/ADDR_WIDTH/DATA_WIDTH/4  request to the SDRAM controller.
REQ-016 mem_ack, mem_valid  in  1/1  controller handshake.
REQ-017 mem_q  in  DATA_WIDTH  controller read data.

Function
REQ-018 The FSM SHALL have three states: ARB, ISSUE and WAIT_RD.
REQ-019 ARB state:
- If no p_req bit is set, remain in ARB.
- Otherwise latch grant, a one-hot register of width N_PORTS, using round-robin: the first requesting port after last_grant, in ascending index order with wrap-around.
- Then go to ISSUE.
REQ-020 ISSUE state:
- mem_req=1.
- mem_we, mem_addr, mem_data and mem_bwe are multiplexed combinationally from the granted port.
- Remain in ISSUE until mem_ack=1.
REQ-021 In the cycle where mem_ack=1 in ISSUE, the block SHALL pulse p_ack of the granted port combinationally.
REQ-022 On the same mem_ack edge, the block SHALL update last_grant to the current grant and move to WAIT_RD if the granted p_we=0, else to ARB.
REQ-023 mem_req SHALL be 0 in every state except ISSUE, so the controller never re-latches a request at the end of its Read, Write or Refresh states.
REQ-024 WAIT_RD state: on mem_valid=1, the block SHALL register mem_q into q and register a p_valid pulse for the granted port, both visible in the next cycle, and return to ARB.
REQ-025 q SHALL hold its value until the next read completes.
REQ-026 In ARB and WAIT_RD, mem_addr, mem_data, mem_we and mem_bwe SHALL be driven from the granted port.
REQ-027 At most one transaction SHALL be outstanding at any time.
REQ-028 Latency: mem_req SHALL rise exactly one cycle after p_req rises while the FSM is in ARB.
REQ-029 Simultaneous requests: the winner is determined by last_grant only. With both ports held continuously, grants alternate 0,1,0,1.
REQ-030 A port requesting alone SHALL receive back-to-back grants, with no idle gap beyond ARB.
REQ-031 A p_req that drops while its port is in ISSUE is a protocol violation. The arbiter SHALL still complete the issued transaction and SHALL still pulse p_ack.
REQ-032 mem_valid arriving outside WAIT_RD SHALL be ignored: no p_valid, and q unchanged.
REQ-033 A mem_ack arriving outside ISSUE SHALL be ignored.
REQ-034 A port's p_req held high after its p_ack is treated as a new request at the next ARB.

Reset
REQ-035 While reset=0, the block SHALL hold:
- state=ARB;
- grant=0;
- last_grant = one-hot bit N_PORTS-1, so port 0 wins first;
- q=0;
- p_ack=0, p_valid=0, mem_req=0.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction immediately. No p_ack or p_valid SHALL be produced for it after reset is released.
REQ-037 After reset is released, the first arbitration SHALL occur on the first rising edge with any p_req=1.

Structure
REQ-038 A shared package SHALL hold the state encoding (ARB=2'd0, ISSUE=2'd1, WAIT_RD=2'd2) and the default ADDR_WIDTH and DATA_WIDTH, shared with the SDRAM controller wrapper.
REQ-039 Round-robin selection SHALL be a sub-module, rr_priority, taking the request vector and last_grant and producing a one-hot grant; it SHALL be purely combinational.
REQ-040 Everything else SHALL be in sdram_arbiter: the FSM, grant registers, muxes and q register.

Verification
REQ-041 Port 0 read only, addr=24'h000123: mem_req rises 1 cycle after p_req. mem_ack is returned after 3 cycles, giving p_ack[0] for 1 cycle. mem_valid with mem_q=32'hDEADBEEF gives p_valid[0] and q=32'hDEADBEEF one cycle later.
REQ-042 Ports 0 and 1 both request from reset: the grant order is 0,1,0,1 over four transactions, and no p_ack goes to a non-granted port.
REQ-043 Port 1 write, data=32'hCAFEF00D, bwe=4'b0011: mem_data=32'hCAFEF00D and mem_bwe=4'b0011 are driven during ISSUE. After mem_ack the FSM returns to ARB and p_valid never pulses.
REQ-044 Spurious mem_valid in ARB: q is unchanged and p_valid=0.
REQ-045 Reset pulled low in WAIT_RD: all outputs go to reset values immediately, and a later mem_valid produces no p_valid.
REQ-046 Controller-refresh delay, with mem_ack held off for 12 cycles: mem_req and the multiplexed fields stay stable for all 12 cycles.
